gf233_reduce_pipe: RTL and testbench

//  Pipelined modular reduction stage for GF(2^233), f(x) = x^233 + x^74 + 1.

---
 rtl/gf233_pkg.sv | 10 +
 rtl/gf233_reduce_pipe_if.sv | 23 ++
 rtl/gf233_fold.sv | 20 ++
 rtl/gf233_reduce_pipe.sv | 79 +++++++
 tb/tb_gf233_reduce_pipe.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf233_pkg.sv
// Shared GF(2^233) constants for the multiplier tree, the reduction stage and later square/inverse stages.
// Field polynomial is f(x) = x^233 + x^74 + 1.
package gf233_pkg;

    localparam int GF_M    = 233;
    localparam int GF_K    = 74;
    localparam int PROD_W  = 2 * GF_M - 1;
    localparam int FOLD1_W = PROD_W - GF_M + GF_K;

endpackage

// File: rtl/gf233_reduce_pipe_if.sv
// Handshake bundle around the reduction stage.
// The slave side is the reducer; the master side is the upstream multiplier plus the downstream consumer.
interface gf233_reduce_pipe_if;
    import gf233_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] prod;
    logic              out_valid;
    logic              out_ready;
    logic [GF_M-1:0]   c;

    modport master (
        output in_valid, prod, out_ready,
        input  in_ready, out_valid, c
    );

    modport slave (
        input  in_valid, prod, out_ready,
        output in_ready, out_valid, c
    );

endinterface

// File: rtl/gf233_fold.sv
// One combinational fold of the terms at x^233 and above back down, using x^233 = x^74 + 1.
// OUT_W must be at least IN_W - 233 + 74 so that the shifted high part fits.
module gf233_fold
    import gf233_pkg::*;
#(
    parameter int IN_W  = PROD_W,
    parameter int OUT_W = FOLD1_W
) (
    input  logic [IN_W-1:0]  fold_in,
    output logic [OUT_W-1:0] fold_out
);

    localparam int H_W = IN_W - GF_M;

    logic [H_W-1:0] h;

    assign h        = fold_in[IN_W-1:GF_M];
    assign fold_out = OUT_W'(fold_in[GF_M-1:0]) ^ OUT_W'(h) ^ (OUT_W'(h) << GF_K);

endmodule

// File: rtl/gf233_reduce_pipe.sv
// Two-stage pipelined reduction of a 465-bit carry-less product modulo x^233 + x^74 + 1.
// Defining GF233_RED_CNT_EN adds the CNT_W parameter and the red_cnt completed-output counter.
module gf233_reduce_pipe
    import gf233_pkg::*;
`ifdef GF233_RED_CNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic                 clk,
    input  logic                 rst_n,
    gf233_reduce_pipe_if.slave   bus
`ifdef GF233_RED_CNT_EN
    ,
    output logic [CNT_W-1:0]     red_cnt
`endif
);

    logic               s1_valid;
    logic [FOLD1_W-1:0] t_q;
    logic [FOLD1_W-1:0] t_next;
    logic               out_valid_q;
    logic [GF_M-1:0]    c_q;
    logic [GF_M-1:0]    c_next;
    logic               adv1;
    logic               adv2;

    gf233_fold #(.IN_W(PROD_W), .OUT_W(FOLD1_W)) u_fold1 (
        .fold_in  (bus.prod),
        .fold_out (t_next)
    );

    // The second fold only sees 73 high bits; g<<74 stays below x^147, so nothing is left to fold.
    gf233_fold #(.IN_W(FOLD1_W), .OUT_W(GF_M)) u_fold2 (
        .fold_in  (t_q),
        .fold_out (c_next)
    );

    assign adv2 = !out_valid_q || bus.out_ready;
    assign adv1 = !s1_valid || adv2;

    assign bus.in_ready  = adv1;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            t_q         <= '0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
        end else begin
            if (adv2) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    c_q <= c_next;
                end
            end
            if (adv1) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    t_q <= t_next;
                end
            end
        end
    end

`ifdef GF233_RED_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_cnt <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            red_cnt <= red_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_gf233_reduce_pipe.sv
// Self-checking bench for gf233_reduce_pipe: directed vector table, random stream, backpressure, reset.
// Expected results come from a bit-serial long-division model and flow through a scoreboard queue.
module tb_gf233_reduce_pipe;
    import gf233_pkg::*;

    localparam int TB_CNT_W = 8;

    typedef struct {
        string             name;
        logic [PROD_W-1:0] prod;
        logic [GF_M-1:0]   exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   n_out;
    logic [GF_M-1:0] sb[$];

    gf233_reduce_pipe_if bus();

`ifdef GF233_RED_CNT_EN
    logic [TB_CNT_W-1:0] red_cnt;
    gf233_reduce_pipe #(.CNT_W(TB_CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .red_cnt (red_cnt)
    );
`else
    gf233_reduce_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [GF_M-1:0] ref_mod(input logic [PROD_W-1:0] p);
        logic [PROD_W-1:0] r;
        r = p;
        for (int i = PROD_W - 1; i >= GF_M; i--) begin
            if (r[i]) begin
                r[i]               = 1'b0;
                r[i-GF_M]          = ~r[i-GF_M];
                r[i-GF_M+GF_K]     = ~r[i-GF_M+GF_K];
            end
        end
        return r[GF_M-1:0];
    endfunction

    function automatic logic [PROD_W-1:0] pbit(input int k);
        logic [PROD_W-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [GF_M-1:0] cbit(input int k);
        logic [GF_M-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [PROD_W-1:0] rand_prod();
        logic [479:0] w;
        for (int j = 0; j < 15; j++) w[j*32 +: 32] = $urandom();
        return w[PROD_W-1:0];
    endfunction

    task automatic check(input string name, input logic [PROD_W-1:0] act, input logic [PROD_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: transfers are decided by the values settled at the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) sb.push_back(ref_mod(bus.prod));
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("sb_unexpected_output", 1, 0);
                end else begin
                    check("sb_result", PROD_W'(bus.c), PROD_W'(sb.pop_front()));
                end
            end
        end
    end

    task automatic drive_hold(input logic [PROD_W-1:0] p, input string name);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.prod     = p;
        @(negedge clk);
        while (!bus.in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) check({name, "_accept_timeout"}, 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        logic [PROD_W-1:0] p[3];
        int out_base;
        int stalls;
        int seen;

        n_checks = 0;
        n_fail   = 0;
        n_out    = 0;

        vecs.push_back('{"x233",        pbit(233),             cbit(74) | cbit(0)});
        vecs.push_back('{"x464",        pbit(464),             cbit(231) | cbit(146) | cbit(72)});
        vecs.push_back('{"x232_x0",     pbit(232) | pbit(0),   cbit(232) | cbit(0)});
        vecs.push_back('{"zero",        '0,                    '0});
        vecs.push_back('{"x233_x0",     pbit(233) | pbit(0),   cbit(74)});
        vecs.push_back('{"x306",        pbit(306),             cbit(73) | cbit(147)});
        vecs.push_back('{"x380",        pbit(380),             cbit(147) | cbit(221)});

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.prod      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", PROD_W'(bus.out_valid), 0);
        check("reset_c", PROD_W'(bus.c), 0);
`ifdef GF233_RED_CNT_EN
        check("reset_red_cnt", PROD_W'(red_cnt), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", PROD_W'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // Directed vectors, each sent alone to verify the exact two-cycle latency.
        foreach (vecs[i]) begin
            bus.in_valid = 1'b1;
            bus.prod     = vecs[i].prod;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            check({vecs[i].name, "_valid_cycle1"}, PROD_W'(bus.out_valid), 0);
            @(negedge clk);
            check({vecs[i].name, "_valid_cycle2"}, PROD_W'(bus.out_valid), 1);
            check({vecs[i].name, "_c"}, PROD_W'(bus.c), PROD_W'(vecs[i].exp));
            @(posedge clk);
            #1;
        end
        idle(2);

        // Random stream at full throughput.
        out_base = n_out;
        stalls   = 0;
        for (int i = 0; i < 1000; i++) begin
            bus.in_valid = 1'b1;
            bus.prod     = rand_prod();
            @(negedge clk);
            if (!bus.in_ready) stalls++;
            @(posedge clk);
            #1;
        end
        idle(4);
        check("stream_stalls", PROD_W'(stalls), 0);
        check("stream_out_count", PROD_W'(n_out - out_base), 1000);
        check("stream_sb_empty", PROD_W'(sb.size()), 0);

        // Backpressure: consumer stalls for five cycles while three products are offered.
        for (int i = 0; i < 3; i++) p[i] = rand_prod();
        out_base      = n_out;
        bus.out_ready = 1'b0;
        drive_hold(p[0], "bp_p0");
        drive_hold(p[1], "bp_p1");
        bus.in_valid = 1'b1;
        bus.prod     = p[2];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", PROD_W'(bus.in_ready), 0);
            check("bp_out_valid_held", PROD_W'(bus.out_valid), 1);
            check("bp_c_stable", PROD_W'(bus.c), PROD_W'(ref_mod(p[0])));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        drive_hold(p[2], "bp_p2");
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_full_swap_valid", PROD_W'(bus.out_valid), 1);
        check("bp_full_swap_c", PROD_W'(bus.c), PROD_W'(ref_mod(p[1])));
        idle(4);
        check("bp_out_count", PROD_W'(n_out - out_base), 3);
        check("bp_sb_empty", PROD_W'(sb.size()), 0);

        // Reset with two products in flight.
        drive_hold(rand_prod(), "rst_p0");
        drive_hold(rand_prod(), "rst_p1");
        check("rst_pre_valid", PROD_W'(bus.out_valid), 1);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rst_async_valid", PROD_W'(bus.out_valid), 0);
        check("rst_async_c", PROD_W'(bus.c), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("rst_no_stale_output", PROD_W'(seen), 0);
`ifdef GF233_RED_CNT_EN
        check("rst_red_cnt_clear", PROD_W'(red_cnt), 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < (1 << TB_CNT_W) - 1; i++) begin
            bus.in_valid = 1'b1;
            bus.prod     = rand_prod();
            @(posedge clk);
            #1;
        end
        idle(4);
        check("cnt_max", PROD_W'(red_cnt), PROD_W'((1 << TB_CNT_W) - 1));
        drive_hold(rand_prod(), "cnt_last");
        idle(4);
        check("cnt_wrap", PROD_W'(red_cnt), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
